cpu_step_controller: RTL and testbench
======================================

# cpu_step_controller

- Sequences the pipelined RISC-V core from the board clock.
- Replaces the raw push-button-as-clock scheme with a single-clock, clock-enable scheme.
- Debounces the step button and runs a single-step / free-run / breakpoint-halt state machine.
- Emits one-cycle `cpu_ce` pulses to the core.
- Exports a step counter and state code for the SSD and LED display paths.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a button level change (board build: 1_000_000).
- `RATE_BASE`, 8: base free-run period in clock cycles.
- `CNT_W`, 16: width of `step_count`.

Ports:
- `clk`  in  1  board clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `step_btn`  in  1  raw step push button, asynchronous, bouncy.
- `run_sw`  in  1  raw run switch, asynchronous; 1 = free-run.
- `rate_sel`  in  2  free-run period select, synchronous.
- `halt_req`  in  1  breakpoint request from core, synchronous to `clk`.
- `cpu_ce`  out  1  one-cycle core clock-enable pulse.
- `step_count`  out  CNT_W  number of `cpu_ce` pulses issued, wraps.
- `state`  out  2  00 IDLE, 01 WAIT_REL, 10 RUN, 11 HALTED.
- `btn_db`  out  1  debounced step button level.

## Operation
- `step_btn` and `run_sw` each pass through a 2-flop synchronizer; `run_sw` is not debounced.
- Debouncer: counter increments while synced `step_btn` != `btn_db` and clears when they are equal. When the count reaches `DEBOUNCE_CYCLES`-1 while differing, `btn_db` toggles and the counter clears.
- `press` is a one-cycle pulse on the `btn_db` 0→1 edge.
- Free-run period P = `RATE_BASE` << (2*`rate_sel`), giving 8/32/128/512 at defaults. The rate counter is `ceil(log2(RATE_BASE))+7` bits.
- IDLE:
  - `run_sw`=1 → RUN, rate counter cleared.
  - Otherwise `press` → `cpu_ce`=1 for exactly the next cycle, then WAIT_REL.
  - Steps are allowed regardless of `halt_req`, so the user can step past a breakpoint.
- WAIT_REL:
  - No pulses.
  - `btn_db`=0 → IDLE.
  - `run_sw` is ignored until IDLE.
- RUN: priority order, highest first:
  1. `run_sw`=0 → IDLE, no pulse.
  2. `halt_req`=1 → HALTED, no pulse.
  3. Rate counter ≥ P-1 → `cpu_ce` pulse next cycle, counter cleared.
  4. Otherwise counter increments.
- HALTED:
  - No pulses.
  - `run_sw`=0 → IDLE.
  - `halt_req` dropping does not exit HALTED.
- `step_count` increments on every cycle `cpu_ce`=1 and wraps from all-ones to 0.
- Reset values: `cpu_ce`=0, `step_count`=0, `state`=00, `btn_db`=0; synchronizers and counters = 0.
- Reset mid-operation: a `cpu_ce` scheduled for the cycle after `rst`=0 is suppressed.
- A `rate_sel` change in RUN takes effect immediately. If the counter is already ≥ new P-1, a pulse is issued next cycle.

## Timing
- `cpu_ce` is registered. The pulse width is always exactly 1 cycle, and two pulses are never adjacent in step mode.
- Step latency: raw `step_btn` held high from edge 0 → `btn_db` rises at edge 2+`DEBOUNCE_CYCLES` → `cpu_ce` high during the cycle after edge 3+`DEBOUNCE_CYCLES`.
- Run: first `cpu_ce` arrives P cycles after the edge that entered RUN, then one every P cycles.
- `run_sw` takes effect 2 cycles after the raw change, via the synchronizer.
- `halt_req` asserted at edge k blocks any pulse scheduled at edge k+1; `state`=11 is visible after edge k.
- `state`, `step_count` and `btn_db` are registered and update on the same edge as their cause.

## Configuration
- `STEP_CTRL_BREAK_EN` defined: `halt_req` is honored as above and HALTED is reachable.
- Not defined: `halt_req` is ignored, RUN never exits except via `run_sw`=0, and `state` never shows 11.

## Test plan
- Reset: hold `rst`=0 3 cycles with `run_sw`=1 → `cpu_ce`=0, `step_count`=0, `state`=00; after release `state`=10 within 3 cycles.
- Bouncy press: toggle `step_btn` every 3 cycles for 30 cycles, then hold high 40 cycles (`DEBOUNCE_CYCLES`=16) → exactly one `cpu_ce`, `step_count`=1, `state`=01 until release is debounced.
- Free-run: `run_sw`=1, `rate_sel`=1 for 200 cycles → pulses spaced exactly 32 cycles, first at 32 after RUN entry, `step_count`=6.
- Breakpoint (macro defined): in RUN assert `halt_req` on the cycle before a pulse is due → no pulse, `state`=11. Drop `run_sw` → `state`=00. Single step still works with `halt_req`=1.
- Wrap/rate change: `CNT_W`=4, run with `rate_sel`=0 for 17 pulses → `step_count`=1. Mid-count switch `rate_sel` 3→0 with counter=100 → pulse next cycle.
- Macro undefined: in RUN assert `halt_req` → `state` stays 10 and pulses continue every P cycles.

Source files
------------

// File: rtl/cpu_step_controller.sv
// rtl/cpu_step_controller.sv - single-clock step/run/breakpoint sequencer emitting cpu_ce pulses
// Optional breakpoint halting is enabled by defining STEP_CTRL_BREAK_EN.
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RATE_BASE       = 8,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic [1:0]       rate_sel,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state,
  output logic             btn_db
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW   = $clog2(RATE_BASE) + 7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_REL = 2'b01,
    S_RUN      = 2'b10,
    S_HALTED   = 2'b11
  } state_t;

  state_t          cur_state, nxt_state;
  logic [1:0]      btn_sync, run_sync;
  logic [DB_W-1:0] db_cnt;
  logic            btn_db_q;
  logic            press, run_on;
  logic [RW-1:0]   rate_cnt, rate_cnt_nxt, period;
  logic            ce_nxt;

  // Synchronizers and button debouncer
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_sync <= 2'b00;
      run_sync <= 2'b00;
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], step_btn};
      run_sync <= {run_sync[0], run_sw};
      btn_db_q <= btn_db;
      if (btn_sync[1] == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press  = btn_db & ~btn_db_q;
  assign run_on = run_sync[1];
  assign period = RW'(RATE_BASE) << {rate_sel, 1'b0};

`ifndef STEP_CTRL_BREAK_EN
  logic unused_halt;
  assign unused_halt = halt_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state  <= S_IDLE;
      cpu_ce     <= 1'b0;
      rate_cnt   <= '0;
      step_count <= '0;
    end else begin
      cur_state <= nxt_state;
      cpu_ce    <= ce_nxt;
      rate_cnt  <= rate_cnt_nxt;
      if (ce_nxt) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

  // Rate compare uses the live rate_sel so a period change applies at once
  always_comb begin
    nxt_state    = cur_state;
    ce_nxt       = 1'b0;
    rate_cnt_nxt = rate_cnt;
    case (cur_state)
      S_IDLE: begin
        if (run_on) begin
          nxt_state    = S_RUN;
          rate_cnt_nxt = '0;
        end else if (press) begin
          ce_nxt    = 1'b1;
          nxt_state = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!btn_db) begin
          nxt_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (!run_on) begin
          nxt_state = S_IDLE;
`ifdef STEP_CTRL_BREAK_EN
        end else if (halt_req) begin
          nxt_state = S_HALTED;
`endif
        end else if (rate_cnt >= period - 1'b1) begin
          ce_nxt       = 1'b1;
          rate_cnt_nxt = '0;
        end else begin
          rate_cnt_nxt = rate_cnt + 1'b1;
        end
      end
      S_HALTED: begin
        if (!run_on) begin
          nxt_state = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_cpu_step_controller.sv
// tb/tb_cpu_step_controller.sv - randomized and directed checks of cpu_step_controller against a timing model
module tb_cpu_step_controller;

  localparam int DB = 16;
  localparam int RB = 8;
  localparam int CW = 4;
`ifdef STEP_CTRL_BREAK_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          step_btn;
  logic          run_sw;
  logic [1:0]    rate_sel;
  logic          halt_req;
  logic          cpu_ce;
  logic [CW-1:0] step_count;
  logic [1:0]    state;
  logic          btn_db;

  cpu_step_controller #(
    .DEBOUNCE_CYCLES(DB),
    .RATE_BASE(RB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step_btn(step_btn),
    .run_sw(run_sw),
    .rate_sel(rate_sel),
    .halt_req(halt_req),
    .cpu_ce(cpu_ce),
    .step_count(step_count),
    .state(state),
    .btn_db(btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: modes, elapsed-time pulse scheduling and a stable-run debouncer
  localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2, M_HALT = 3;
  int   edge_no = 0;
  int   m_mode = M_IDLE, m_anchor = 0, m_run_len = 0, m_count = 0;
  bit   m_db = 0, m_db_prev = 0, m_ce = 0;
  bit   raw_btn_1 = 0, raw_btn_2 = 0, raw_run_1 = 0, raw_run_2 = 0;

  always @(posedge clk) begin : model
    bit s_btn, s_run, prs;
    int per;
    edge_no++;
    if (!rst) begin
      m_mode = M_IDLE; m_anchor = 0; m_run_len = 0; m_count = 0;
      m_db = 0; m_db_prev = 0; m_ce = 0;
      raw_btn_1 = 0; raw_btn_2 = 0; raw_run_1 = 0; raw_run_2 = 0;
    end else begin
      s_btn = raw_btn_2;
      s_run = raw_run_2;
      prs   = m_db && !m_db_prev;
      per   = RB * (4 ** rate_sel);
      m_ce  = 0;
      case (m_mode)
        M_IDLE: if (s_run) begin m_mode = M_RUN; m_anchor = edge_no; end
                else if (prs) begin m_ce = 1; m_mode = M_WAIT; end
        M_WAIT: if (!m_db) m_mode = M_IDLE;
        M_RUN:  if (!s_run) m_mode = M_IDLE;
                else if (BREAK_EN && halt_req) m_mode = M_HALT;
                else if (edge_no - m_anchor >= per) begin m_ce = 1; m_anchor = edge_no; end
        default: if (!s_run) m_mode = M_IDLE;
      endcase
      if (m_ce) m_count = (m_count + 1) % (1 << CW);
      m_db_prev = m_db;
      if (s_btn != m_db) begin
        m_run_len++;
        if (m_run_len == DB) begin m_db = !m_db; m_run_len = 0; end
      end else begin
        m_run_len = 0;
      end
      raw_btn_2 = raw_btn_1; raw_btn_1 = step_btn;
      raw_run_2 = raw_run_1; raw_run_1 = run_sw;
    end
  end

  always @(negedge clk) begin
    if (edge_no > 0) begin
      check_eq("m_ce", cpu_ce, m_ce);
      check_eq("m_state", state, m_mode);
      check_eq("m_count", step_count, m_count);
      check_eq("m_db", btn_db, m_db);
    end
  end

  int win_pulses, win_idx, run_at;
  int pulse_at[$];

  task automatic clear_win();
    win_pulses = 0; win_idx = 0; run_at = -1; pulse_at.delete();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      win_idx++;
      if (cpu_ce) begin win_pulses++; pulse_at.push_back(win_idx); end
      if (state == 2'b10 && run_at < 0) run_at = win_idx;
    end
  endtask

  task automatic wait_run(input string tag);
    int b;
    b = 0;
    while (state != 2'b10 && b < 10) begin cycles(1); b++; end
    check_eq(tag, state, 2);
  endtask

  initial begin
    int b;
    rst = 0; step_btn = 0; run_sw = 1; rate_sel = 3; halt_req = 0;
    clear_win();
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check_eq("rst_ce", cpu_ce, 0);
      check_eq("rst_state", state, 0);
      check_eq("rst_count", step_count, 0);
    end
    rst = 1;
    cycles(3);
    check_eq("rst_release_run", state, 2);
    run_sw = 0;
    cycles(8);
    check_eq("run_exit", state, 0);

    // Bouncy press then clean hold
    for (int i = 0; i < 10; i++) begin step_btn = ~step_btn; cycles(3); end
    check_eq("bounce_db", btn_db, 0);
    step_btn = 1;
    clear_win();
    cycles(40);
    check_eq("step_pulses", win_pulses, 1);
    check_eq("step_latency", pulse_at.size() > 0 ? pulse_at[0] : -1, DB + 3);
    check_eq("step_count1", step_count, 1);
    check_eq("step_wait_rel", state, 1);
    step_btn = 0;
    cycles(30);
    check_eq("step_release", state, 0);

    // Free run at P=32
    rate_sel = 1; run_sw = 1;
    clear_win();
    cycles(200);
    check_eq("run_pulses", win_pulses, 6);
    check_eq("run_first", pulse_at.size() > 0 ? pulse_at[0] - run_at : -1, 32);
    for (int i = 1; i < pulse_at.size(); i++) check_eq("run_gap", pulse_at[i] - pulse_at[i-1], 32);
    check_eq("run_count", step_count, 7);
    run_sw = 0;
    cycles(6);
    check_eq("run_stop", state, 0);

    // Breakpoint the edge a pulse is due
    rate_sel = 0; run_sw = 1;
    wait_run("brk_enter");
    cycles(7);
    halt_req = 1;
    clear_win();
    cycles(1);
    check_eq("brk_state", state, BREAK_EN ? 3 : 2);
    check_eq("brk_ce", cpu_ce, BREAK_EN ? 0 : 1);
    clear_win();
    cycles(16);
    check_eq("brk_pulses", win_pulses, BREAK_EN ? 0 : 2);
    halt_req = 0;
    cycles(3);
    check_eq("brk_hold", state, BREAK_EN ? 3 : 2);
    run_sw = 0;
    cycles(4);
    check_eq("brk_exit", state, 0);
    halt_req = 1; step_btn = 1;
    clear_win();
    cycles(25);
    check_eq("brk_step", win_pulses, 1);
    step_btn = 0;
    cycles(25);
    halt_req = 0;

    // 17 pulses on a 4-bit counter
    rst = 0;
    cycles(2);
    rst = 1; run_sw = 1; rate_sel = 0;
    clear_win();
    b = 0;
    while (win_pulses < 17 && b < 400) begin cycles(1); b++; end
    run_sw = 0;
    cycles(5);
    check_eq("wrap_pulses", win_pulses, 17);
    check_eq("wrap_count", step_count, 1);

    // Period shrinks below the running count
    rate_sel = 3; run_sw = 1;
    wait_run("rate_enter");
    clear_win();
    cycles(100);
    check_eq("rate_quiet", win_pulses, 0);
    rate_sel = 0;
    cycles(1);
    check_eq("rate_switch_ce", cpu_ce, 1);
    run_sw = 0;
    cycles(5);

    // Reset on the edge a pulse is due
    run_sw = 1;
    wait_run("rstmid_enter");
    cycles(7);
    rst = 0;
    cycles(1);
    check_eq("rstmid_ce", cpu_ce, 0);
    check_eq("rstmid_state", state, 0);
    rst = 1; run_sw = 0;
    cycles(4);

    // Random mix, checked by the model
    for (int seg = 0; seg < 70; seg++) begin
      step_btn = 1'($urandom_range(0, 1));
      run_sw   = ($urandom_range(0, 3) == 0);
      rate_sel = 2'($urandom_range(0, 2) == 2 ? $urandom_range(0, 3) : $urandom_range(0, 1));
      halt_req = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 24) != 0);
      cycles(rst ? $urandom_range(1, 45) : 2);
      rst = 1;
    end
    step_btn = 0; run_sw = 0; halt_req = 0;
    cycles(40);
    check_eq("end_idle", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
